// File: rtl/fu_sub_nibser.sv
// Nibble-serial subtractor: din1 - din2 computed one 4-bit carry-lookahead nibble per clock, with borrow/overflow/zero flags.
// Latency: start sampled at edge E0 -> done pulses after edge E0+N (N = WIDTH/4); one op per N+1 cycles back-to-back.
// Backpressure: none; start is ignored while busy, with no queueing. Optional slt output when FU_SUB_SLT_EN is defined.
module fu_sub_nibser #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
`ifdef FU_SUB_SLT_EN
    ,
    output logic             slt
`endif
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;      // holds ~din2
    logic [WIDTH-1:0] acc_q;      // lower nibbles accumulated during RUN
    logic [WIDTH-1:0] dout_q;
    logic             done_q;
    logic             borrow_q;
    logic             ovf_q;
    logic             zero_q;
    logic             slt_q;

    logic [3:0]       a_nib, b_nib, p, g, sum_nib;
    logic [4:0]       c;
    logic [WIDTH-1:0] res_full;
    logic             last;
    logic             ovf_nib;

    // Select the current nibble of both operands and run the 4-bit carry-lookahead add.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                a_nib = op1_q[k*4 +: 4];
                b_nib = op2_q[k*4 +: 4];
            end
        end
        p    = a_nib ^ b_nib;
        g    = a_nib & b_nib;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum_nib = p ^ c[3:0];
        // Carry into the MSB bit vs carry out of it; meaningful on the last nibble only.
        ovf_nib = c[3] ^ c[4];
        last    = (cnt_q == CW'(N - 1));
    end

    // Merge the freshly computed nibble into the stored lower nibbles.
    always_comb begin
        res_full = acc_q;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                res_full[k*4 +: 4] = sum_nib;
            end
        end
    end

    // Next-state decode: accept start only in IDLE, leave RUN after the final nibble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, per-nibble carry ripple, and flag/result update on the final edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            acc_q    <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            slt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (state_q == S_IDLE) begin
                if (start) begin
                    op1_q   <= din1;
                    op2_q   <= ~din2;
                    carry_q <= 1'b1;
                    cnt_q   <= '0;
                end
            end else begin
                acc_q   <= res_full;
                carry_q <= c[4];
                if (last) begin
                    cnt_q    <= '0;
                    dout_q   <= res_full;
                    borrow_q <= ~c[4];
                    ovf_q    <= ovf_nib;
                    zero_q   <= (res_full == '0);
                    slt_q    <= ovf_nib ^ sum_nib[3];
                    done_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign busy       = (state_q == S_RUN);
    assign done       = done_q;
    assign dout       = dout_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;

`ifdef FU_SUB_SLT_EN
    assign slt = slt_q;
`else
    logic unused_slt;
    assign unused_slt = slt_q;
`endif

endmodule
